// File: rtl/control_unit.sv
// control_unit: hardwired T-state sequencer driving every datapath strobe.
// Fetch T0..T2, then a per-opcode execute phase; outputs are a Moore decode of
// the state register and IR[31:27] (CON_FF also gates the br T6 strobes).
// Ports: Clock/clear (sync active-high), IR, CON_FF, Stop in; Run, Illegal,
// opcode and all strobes out. Reserved strobes (HI/LO/port/etc.) are held 0.
// Optional macro ILLEGAL_TRAP_EN: undefined opcodes halt with Illegal=1;
// when undefined, they run as nop and Illegal is tied 0.
module control_unit #(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic        Illegal,
  output logic [4:0]  opcode,
  output logic        Read, Write, IncPC,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        Yin, Zin, PCin, IRin, MARin, MDRin, CONin,
  output logic        Zlowout, PCout, MDRout, Cout,
  output logic        HIin, LOin, HIout, LOout, Yout, Zhighout, MARout,
  output logic        Inportin, Inportout, Outportin, Outportout
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  logic [3:0] state, nxt;
  logic [4:0] op;
  logic       unused_ir;
  logic       is_ld, is_ldi, is_st, is_alu, is_imm, is_br, is_jr, is_nop, is_halt, is_undef;
  logic [3:0] done_nxt;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  assign is_ld    = (op == 5'b00000);
  assign is_ldi   = (op == 5'b00001);
  assign is_st    = (op == 5'b00010);
  assign is_alu   = (op >= 5'b00011) && (op <= 5'b01011);
  assign is_imm   = (op >= 5'b01100) && (op <= 5'b01110);
  assign is_br    = (op == 5'b10010);
  assign is_jr    = (op == 5'b10100);
  assign is_nop   = (op == 5'b11000);
  assign is_halt  = (op == 5'b11001);
  assign is_undef = !(is_ld | is_ldi | is_st | is_alu | is_imm | is_br | is_jr | is_nop | is_halt);

  // Instruction boundary: Stop is only looked at here.
  assign done_nxt = Stop ? S_HALT : S_T0;

  always_comb begin
    nxt = state;
    case (state)
      S_RESET: nxt = S_T0;
      S_T0:    nxt = S_T1;
      S_T1:    nxt = S_T2;
      S_T2: begin
        if (is_undef) begin
`ifdef ILLEGAL_TRAP_EN
          nxt = S_HALT;
`else
          nxt = done_nxt;
`endif
        end else if (is_nop) nxt = done_nxt;
        else                 nxt = S_T3;
      end
      S_T3:    nxt = is_halt ? S_HALT : (is_jr ? done_nxt : S_T4);
      S_T4:    nxt = S_T5;
      S_T5:    nxt = (is_ldi | is_alu | is_imm) ? done_nxt : S_T6;
      S_T6:    nxt = is_br ? done_nxt : S_T7;
      S_T7:    nxt = done_nxt;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_RESET;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) state <= S_RESET;
    else       state <= nxt;
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge Clock) begin
    if (clear)                         illegal_q <= 1'b0;
    else if (state == S_T2 && is_undef) illegal_q <= 1'b1;
  end
  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

  assign Run = (state != S_RESET) && (state != S_HALT);

  always_comb begin
    opcode = 5'b00000;
    Read = 1'b0; Write = 1'b0; IncPC = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Yin = 1'b0; Zin = 1'b0; PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; CONin = 1'b0;
    Zlowout = 1'b0; PCout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_ld | is_ldi | is_st) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else if (is_alu | is_imm)   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_br)             begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        else if (is_jr)             begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
      end
      S_T4: begin
        if (is_ld | is_ldi | is_st) begin Cout = 1'b1; Zin = 1'b1; opcode = ADD_OP; end
        else if (is_alu)            begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
        else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1;
          case (op)
            5'b01100: opcode = 5'b00011;
            5'b01101: opcode = 5'b00101;
            default:  opcode = 5'b00110;
          endcase
        end
        else if (is_br)             begin PCout = 1'b1; Yin = 1'b1; end
      end
      S_T5: begin
        if (is_ld | is_st)                 begin Zlowout = 1'b1; MARin = 1'b1; end
        else if (is_ldi | is_alu | is_imm) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_br)                    begin Cout = 1'b1; Zin = 1'b1; opcode = ADD_OP; end
      end
      S_T6: begin
        if (is_ld)                begin Read = 1'b1; MDRin = 1'b1; end
        else if (is_st)           begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else if (is_br && CON_FF) begin Zlowout = 1'b1; PCin = 1'b1; end
      end
      S_T7: begin
        if (is_ld)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_st) Write = 1'b1;
      end
      default: ;
    endcase
  end

  assign HIin = 1'b0;      assign LOin = 1'b0;      assign HIout = 1'b0;
  assign LOout = 1'b0;     assign Yout = 1'b0;      assign Zhighout = 1'b0;
  assign MARout = 1'b0;    assign Inportin = 1'b0;  assign Inportout = 1'b0;
  assign Outportin = 1'b0; assign Outportout = 1'b0;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: per-cycle vector table of inputs and expected
// strobes/opcode/Run/Illegal, plus a hand-written Stop-at-boundary length check.
module tb_control_unit;

  logic        Clock, clear, CON_FF, Stop;
  logic [31:0] IR;
  logic        Run, Illegal;
  logic [4:0]  opcode;
  logic Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
  logic Yin, Zin, PCin, IRin, MARin, MDRin, CONin, Zlowout, PCout, MDRout, Cout;
  logic HIin, LOin, HIout, LOout, Yout, Zhighout, MARout, Inportin, Inportout, Outportin, Outportout;

  control_unit dut (
    .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .Run(Run), .Illegal(Illegal), .opcode(opcode),
    .Read(Read), .Write(Write), .IncPC(IncPC),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .CONin(CONin),
    .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout), .Cout(Cout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .Yout(Yout), .Zhighout(Zhighout),
    .MARout(MARout), .Inportin(Inportin), .Inportout(Inportout),
    .Outportin(Outportin), .Outportout(Outportout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef logic [20:0] strb_t;
  localparam strb_t READ = 21'h1 << 0,  WRITE = 21'h1 << 1,  INCPC = 21'h1 << 2;
  localparam strb_t GRA  = 21'h1 << 3,  GRB   = 21'h1 << 4,  GRC   = 21'h1 << 5;
  localparam strb_t RIN  = 21'h1 << 6,  ROUT  = 21'h1 << 7,  BAOUT = 21'h1 << 8;
  localparam strb_t YIN  = 21'h1 << 9,  ZIN   = 21'h1 << 10, PCIN  = 21'h1 << 11;
  localparam strb_t IRIN = 21'h1 << 12, MARIN = 21'h1 << 13, MDRIN = 21'h1 << 14;
  localparam strb_t CONIN = 21'h1 << 15, ZLOW = 21'h1 << 16, PCOUT = 21'h1 << 17;
  localparam strb_t MDROUT = 21'h1 << 18, COUT = 21'h1 << 19;
  localparam strb_t NONE = 21'h0;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011;
  localparam logic [4:0] ANDR = 5'b00101, ANDI = 5'b01101, ORI = 5'b01110;
  localparam logic [4:0] BR = 5'b10010, JR = 5'b10100, NOP = 5'b11000, HLT = 5'b11001, BAD = 5'b11111;

  strb_t obs;
  logic  rsv;
  assign rsv = HIin | LOin | HIout | LOout | Yout | Zhighout | MARout |
               Inportin | Inportout | Outportin | Outportout;
  assign obs = {rsv, Cout, MDRout, PCout, Zlowout, CONin, MDRin, MARin, IRin, PCin, Zin, Yin,
                BAout, Rout, Rin, Grc, Grb, Gra, IncPC, Write, Read};

  typedef struct {
    logic       clr;
    logic [4:0] op;
    logic       con;
    logic       stp;
    strb_t      strb;
    logic [4:0] opc;
    logic       run;
    logic       ill;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic add(input logic clr, input logic [4:0] op, input logic con, input logic stp,
                     input strb_t s, input logic [4:0] opc, input logic run, input logic ill);
    vec_t v;
    v.clr = clr; v.op = op; v.con = con; v.stp = stp;
    v.strb = s; v.opc = opc; v.run = run; v.ill = ill;
    tbl.push_back(v);
  endtask

  // Normal running-cycle row: clear=0, Run=1, Illegal=0.
  task automatic row(input logic [4:0] op, input logic con, input logic stp,
                     input strb_t s, input logic [4:0] opc);
    add(1'b0, op, con, stp, s, opc, 1'b1, 1'b0);
  endtask

  task automatic fetch(input logic [4:0] op, input logic stp);
    row(op, 1'b0, stp, PCOUT | MARIN | INCPC | ZIN, 5'd0);
    row(op, 1'b0, stp, ZLOW | PCIN | READ | MDRIN, 5'd0);
    row(op, 1'b0, stp, MDROUT | IRIN, 5'd0);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
    else n_pass++;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge Clock);
    clear = v.clr; IR = {v.op, 27'h0}; CON_FF = v.con; Stop = v.stp;
    #1;
    chk("strobes", idx, {11'h0, obs}, {11'h0, v.strb});
    chk("opcode", idx, {27'h0, opcode}, {27'h0, v.opc});
    chk("run", idx, {31'h0, Run}, {31'h0, v.run});
    chk("illegal", idx, {31'h0, Illegal}, {31'h0, v.ill});
  endtask

  initial begin
    int cnt;
    clear = 1'b1; IR = 32'h0; CON_FF = 1'b0; Stop = 1'b0;

    // Reset held two cycles, then released (still RESET in that cycle).
    add(1'b1, LD, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    add(1'b1, LD, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    add(1'b0, LD, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    // ld
    fetch(LD, 1'b0);
    row(LD, 0, 0, GRB | BAOUT | YIN, 5'd0);
    row(LD, 0, 0, COUT | ZIN, ADD);
    row(LD, 0, 0, ZLOW | MARIN, 5'd0);
    row(LD, 0, 0, READ | MDRIN, 5'd0);
    row(LD, 0, 0, MDROUT | GRA | RIN, 5'd0);
    // ldi
    fetch(LDI, 1'b0);
    row(LDI, 0, 0, GRB | BAOUT | YIN, 5'd0);
    row(LDI, 0, 0, COUT | ZIN, ADD);
    row(LDI, 0, 0, ZLOW | GRA | RIN, 5'd0);
    // st
    fetch(ST, 1'b0);
    row(ST, 0, 0, GRB | BAOUT | YIN, 5'd0);
    row(ST, 0, 0, COUT | ZIN, ADD);
    row(ST, 0, 0, ZLOW | MARIN, 5'd0);
    row(ST, 0, 0, GRA | ROUT | MDRIN, 5'd0);
    row(ST, 0, 0, WRITE, 5'd0);
    // and (register)
    fetch(ANDR, 1'b0);
    row(ANDR, 0, 0, GRB | ROUT | YIN, 5'd0);
    row(ANDR, 0, 0, GRC | ROUT | ZIN, ANDR);
    row(ANDR, 0, 0, ZLOW | GRA | RIN, 5'd0);
    // andi, ori
    fetch(ANDI, 1'b0);
    row(ANDI, 0, 0, GRB | ROUT | YIN, 5'd0);
    row(ANDI, 0, 0, COUT | ZIN, 5'b00101);
    row(ANDI, 0, 0, ZLOW | GRA | RIN, 5'd0);
    fetch(ORI, 1'b0);
    row(ORI, 0, 0, GRB | ROUT | YIN, 5'd0);
    row(ORI, 0, 0, COUT | ZIN, 5'b00110);
    row(ORI, 0, 0, ZLOW | GRA | RIN, 5'd0);
    // br taken (CON_FF=1 only in T6), then not taken (CON_FF=1 until T6)
    fetch(BR, 1'b0);
    row(BR, 0, 0, GRA | ROUT | CONIN, 5'd0);
    row(BR, 0, 0, PCOUT | YIN, 5'd0);
    row(BR, 0, 0, COUT | ZIN, ADD);
    row(BR, 1, 0, ZLOW | PCIN, 5'd0);
    fetch(BR, 1'b0);
    row(BR, 1, 0, GRA | ROUT | CONIN, 5'd0);
    row(BR, 1, 0, PCOUT | YIN, 5'd0);
    row(BR, 1, 0, COUT | ZIN, ADD);
    row(BR, 0, 0, NONE, 5'd0);
    // jr with Stop pulsed during fetch: must not truncate
    fetch(JR, 1'b1);
    row(JR, 0, 0, GRA | ROUT | PCIN, 5'd0);
    // nop straight back to fetch
    fetch(NOP, 1'b0);
    // add with Stop raised in T4: T5 completes, then HALT until clear
    fetch(ADD, 1'b0);
    row(ADD, 0, 0, GRB | ROUT | YIN, 5'd0);
    row(ADD, 0, 1, GRC | ROUT | ZIN, ADD);
    row(ADD, 0, 1, ZLOW | GRA | RIN, 5'd0);
    add(1'b0, ADD, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    add(1'b0, ADD, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    add(1'b1, ADD, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    add(1'b0, HLT, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    // halt opcode: T3 then HALT, held until clear
    fetch(HLT, 1'b0);
    row(HLT, 0, 0, NONE, 5'd0);
    add(1'b0, HLT, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    add(1'b0, HLT, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    add(1'b1, HLT, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    add(1'b0, LD, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    // clear mid-instruction aborts ld in T3
    fetch(LD, 1'b0);
    add(1'b1, LD, 1'b0, 1'b0, GRB | BAOUT | YIN, 5'd0, 1'b1, 1'b0);
    add(1'b0, NOP, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    fetch(NOP, 1'b0);
    // undefined opcode
    fetch(BAD, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    add(1'b0, BAD, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b1);
    add(1'b0, BAD, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b1);
    add(1'b1, BAD, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b1);
    add(1'b0, NOP, 1'b0, 1'b0, NONE, 5'd0, 1'b0, 1'b0);
    fetch(NOP, 1'b0);
`else
    fetch(NOP, 1'b0);
`endif

    repeat (2) @(posedge Clock);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Stop held high through a whole ld: exactly 8 Run cycles, then HALT.
    @(negedge Clock); clear = 1'b1; Stop = 1'b0;
    @(negedge Clock); clear = 1'b0; IR = {LD, 27'h0}; Stop = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock); #1;
      if (Run) cnt++;
      else if (cnt > 0) break;
    end
    chk("ld_len_stop", 0, cnt, 32'd8);
    #1;
    chk("halt_after_stop", 0, {31'h0, Run}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
